// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  // Byte offset bits inside one 16-byte cache line.
  localparam int unsigned LINE_OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_req_latch.sv
// Holds the granted request (op, line-aligned address, write data) for the
// duration of one physical-memory transaction.
module cache_arb_req_latch
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic                  lat_read,
  output logic                  lat_write,
  output logic [ADDR_WIDTH-1:0] lat_address,
  output logic [LINE_WIDTH-1:0] lat_wdata
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_read    <= 1'b0;
      lat_write   <= 1'b0;
      lat_address <= '0;
      lat_wdata   <= '0;
    end else if (load) begin
      lat_read    <= read;
      lat_write   <= write;
      lat_address <= {address[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      lat_wdata   <= wdata;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Merges I-cache and D-cache line requests onto one physical memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state, next_state;
  logic d_req, grant_d, grant_i, load;
  logic lat_read, lat_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [LINE_WIDTH-1:0] sel_wdata;

  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = I, 1 = D

  assign grant_d = d_req & ~(i_pmem_read & last_grant);
  assign grant_i = i_pmem_read & ~grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b0;
    else if (load)
      last_grant <= grant_d;
  end
`else
  assign grant_d = d_req;
  assign grant_i = i_pmem_read & ~d_req;
`endif

  assign load        = (state == IDLE) & (grant_d | grant_i);
  assign sel_address = grant_d ? d_pmem_address : i_pmem_address;
  assign sel_wdata   = grant_d ? d_pmem_wdata : '0;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d)
          next_state = SERVE_D;
        else if (grant_i)
          next_state = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A simultaneous read+write from D resolves to a write.
  cache_arb_req_latch #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_req_latch (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .read       (grant_d ? (d_pmem_read & ~d_pmem_write) : 1'b1),
    .write      (grant_d & d_pmem_write),
    .address    (sel_address),
    .wdata      (sel_wdata),
    .lat_read   (lat_read),
    .lat_write  (lat_write),
    .lat_address(pmem_address),
    .lat_wdata  (pmem_wdata)
  );

  assign pmem_read    = (state != IDLE) & lat_read;
  assign pmem_write   = (state != IDLE) & lat_write;
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a transaction-level model.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp;

  logic resp_r = 1'b0;
  logic stray = 1'b0;
  int   mem_lat = 3;
  int   mem_cnt = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign pmem_resp = resp_r | stray;

  cache_arbiter #(
    .ADDR_WIDTH(16),
    .LINE_WIDTH(128)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: answers any strobe after mem_lat strobe cycles, one-cycle resp.
  always @(posedge clk) begin
    #1;
    if (reset || resp_r) begin
      resp_r  = 1'b0;
      mem_cnt = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) resp_r = 1'b1;
    end
  end

  // Transaction model: owner 0 = none, 1 = I, 2 = D.
  bit           m_busy = 0;
  int           m_owner = 0;
  bit           m_write = 0;
  bit           m_last_d = 0;
  logic [15:0]  m_addr = '0;
  logic [127:0] m_wdata = '0;
  bit           m_want_d, m_pick_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_owner = 0; m_write = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy = 0;
        m_owner = 0;
      end
    end else begin
      m_want_d = d_pmem_read || d_pmem_write;
      m_pick_d = m_want_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      if (m_want_d && i_pmem_read && m_last_d) m_pick_d = 0;
`endif
      if (m_pick_d) begin
        m_busy = 1; m_owner = 2; m_last_d = 1;
        m_write = d_pmem_write;
        m_addr = d_pmem_address & 16'hFFF0;
        m_wdata = d_pmem_wdata;
      end else if (i_pmem_read) begin
        m_busy = 1; m_owner = 1; m_last_d = 0;
        m_write = 0;
        m_addr = i_pmem_address & 16'hFFF0;
      end
    end
  end

  always @(negedge clk) begin
    chk("pmem_read", pmem_read, m_busy && !m_write);
    chk("pmem_write", pmem_write, m_busy && m_write);
    chk("i_resp", i_pmem_resp, m_owner == 1 && pmem_resp);
    chk("d_resp", d_pmem_resp, m_owner == 2 && pmem_resp);
    if (m_busy || reset) chk("pmem_address", pmem_address, reset ? 16'h0 : m_addr);
    if ((m_busy && m_write) || reset) chk("pmem_wdata", pmem_wdata, reset ? 128'h0 : m_wdata);
    if (m_owner == 1 && pmem_resp) chk("i_rdata", i_pmem_rdata, pmem_rdata);
    if (m_owner == 2 && pmem_resp) chk("d_rdata", d_pmem_rdata, pmem_rdata);
  end

  task automatic wait_resp(input bit is_d, output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (is_d ? d_pmem_resp : i_pmem_resp) begin
        ok = 1;
        return;
      end
    end
    chk(is_d ? "d_timeout" : "i_timeout", 1'b0, 1'b1);
  endtask

  task automatic drop(input bit is_d);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_pmem_read = 0;
      d_pmem_write = 0;
    end else begin
      i_pmem_read = 0;
    end
  endtask

  bit ok, first_d;
  int pulses;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_address", pmem_address, 16'h0);
    @(posedge clk);
    #2 reset = 0;

    // I-only fill
    @(posedge clk); #1;
    pmem_rdata = {8{16'hAAAA}};
    i_pmem_read = 1; i_pmem_address = 16'h1234;
    @(negedge clk);
    chk("i_grant_idle_cycle", pmem_read, 1'b0);
    @(negedge clk);
    chk("i_strobe_next_cycle", pmem_read, 1'b1);
    chk("i_addr_aligned", pmem_address, 16'h1230);
    wait_resp(0, ok);
    chk("i_rdata_lit", i_pmem_rdata, {8{16'hAAAA}});
    chk("i_d_resp_quiet", d_pmem_resp, 1'b0);
    drop(0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_pmem_resp) pulses++;
    end
    chk("i_resp_single_pulse", pulses, 0);

    // D writeback then fill
    @(posedge clk); #1;
    d_pmem_write = 1; d_pmem_address = 16'h4560; d_pmem_wdata = {8{16'h5555}};
    wait_resp(1, ok);
    chk("d_wb_write", pmem_write, 1'b1);
    chk("d_wb_wdata", pmem_wdata, {8{16'h5555}});
    @(posedge clk); #1;
    d_pmem_write = 0; d_pmem_read = 1; d_pmem_address = 16'h8820;
    pmem_rdata = {4{32'h0123_4567}};
    @(negedge clk);
    chk("d_idle_gap", pmem_read | pmem_write, 1'b0);
    @(negedge clk);
    chk("d_fill_read", pmem_read, 1'b1);
    chk("d_fill_addr", pmem_address, 16'h8820);
    wait_resp(1, ok);
    chk("d_rdata_lit", d_pmem_rdata, {4{32'h0123_4567}});
    drop(1);

    // Simultaneous requests, last grant was D
    @(posedge clk); #1;
    i_pmem_read = 1; i_pmem_address = 16'h0100;
    d_pmem_read = 1; d_pmem_address = 16'h2200;
    first_d = 0; ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (d_pmem_resp || i_pmem_resp) begin
        ok = 1;
        first_d = d_pmem_resp;
      end
    end
    chk("both_first_found", ok, 1'b1);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    chk("both_first_is_d", first_d, 1'b0);
`else
    chk("both_first_is_d", first_d, 1'b1);
    chk("both_i_waits", i_pmem_resp, 1'b0);
`endif
    drop(first_d);
    wait_resp(!first_d, ok);
    chk("both_second_addr", pmem_address, first_d ? 16'h0100 : 16'h2200);
    drop(!first_d);

    // Stray pmem_resp while idle
    @(posedge clk); #1 stray = 1;
    @(negedge clk);
    chk("stray_i_resp", i_pmem_resp, 1'b0);
    chk("stray_d_resp", d_pmem_resp, 1'b0);
    @(posedge clk); #1 stray = 0;

    // D address changes mid-transaction
    @(posedge clk); #1;
    mem_lat = 6;
    d_pmem_read = 1; d_pmem_address = 16'h3330;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 d_pmem_address = 16'hFFF0;
    @(negedge clk);
    chk("d_hold_addr", pmem_address, 16'h3330);
    wait_resp(1, ok);
    chk("d_hold_addr_resp", pmem_address, 16'h3330);
    drop(1);

    // Reset mid SERVE_I with D pending
    @(posedge clk); #1;
    mem_lat = 8;
    i_pmem_read = 1; i_pmem_address = 16'h0400;
    repeat (2) @(negedge clk);
    chk("rst_pre_strobe", pmem_read, 1'b1);
    @(posedge clk); #1;
    d_pmem_read = 1; d_pmem_address = 16'h7770;
    @(negedge clk); #2;
    reset = 1; i_pmem_read = 0;
    #1;
    chk("rst_async_read", pmem_read, 1'b0);
    chk("rst_async_addr", pmem_address, 16'h0);
    @(posedge clk); #2 reset = 0;
    mem_lat = 3;
    wait_resp(1, ok);
    chk("rst_then_d_addr", pmem_address, 16'h7770);
    drop(1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
